// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and default widths for the memory port arbiter.
package mem_arb_pkg;

    localparam int unsigned DEF_ADDR_W   = 16;
    localparam int unsigned DEF_DATA_W   = 16;
    localparam int unsigned DEF_MEM_LAT  = 1;
    localparam int unsigned DEF_MAX_WAIT = 4;

    // Starvation counter and read-latency counter widths (MAX_WAIT <= 15, MEM_LAT <= 7).
    localparam int unsigned WAIT_CNT_W = 4;
    localparam int unsigned LAT_CNT_W  = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        ACK   = 2'd3
    } arb_state_e;

    // 0 = CPU load/store port, 1 = debug/IO port.
    typedef logic port_id_t;

endpackage

// File: rtl/mem_arb_select.sv
// mem_arb_select: combinational winner selection between the two requesters.
// Port 0 wins contention unless port 1 has already lost MAX_WAIT times in a row.
module mem_arb_select
    import mem_arb_pkg::*;
#(
    parameter int unsigned MAX_WAIT = DEF_MAX_WAIT
)(
    input  logic                  req0,
    input  logic                  req1,
    input  logic [WAIT_CNT_W-1:0] wait_cnt,
    output logic                  any_req,
    output port_id_t              winner
);

    localparam logic [WAIT_CNT_W-1:0] MAX_WAIT_C = WAIT_CNT_W'(MAX_WAIT);

    // Pick the winner; the value only matters when any_req is high.
    always_comb begin
        any_req = req0 | req1;
        winner  = 1'b0;
        if (req1 && !req0) begin
            winner = 1'b1;
        end else if (req1 && req0 && (wait_cnt == MAX_WAIT_C)) begin
            winner = 1'b1;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares a single-port data memory between the CPU (port 0)
// and a debug/IO requester (port 1).
// Optional feature macro: MEM_PORT_ARBITER_PERF_EN adds saturating per-port
// grant counters grant_cnt0/grant_cnt1.
// Handshake: a requester raises reqN with weN/addrN/wdataN stable and holds
// them until ackN. ackN is a one-cycle pulse; for loads rdataN is valid with
// ackN and holds until that port's next ack. reqN still high in the cycle after
// ackN is a new request.
// Memory timing: mem_en is high for exactly one cycle per access; mem_rdata is
// sampled on the clock edge that ends the MEM_LAT-th cycle counted from (and
// including) the mem_en cycle.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W   = DEF_ADDR_W,
    parameter int unsigned DATA_W   = DEF_DATA_W,
    parameter int unsigned MEM_LAT  = DEF_MEM_LAT,
    parameter int unsigned MAX_WAIT = DEF_MAX_WAIT
)(
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  req0,
    input  logic                  we0,
    input  logic [ADDR_W-1:0]     addr0,
    input  logic [DATA_W-1:0]     wdata0,
    output logic                  ack0,
    output logic [DATA_W-1:0]     rdata0,
    input  logic                  req1,
    input  logic                  we1,
    input  logic [ADDR_W-1:0]     addr1,
    input  logic [DATA_W-1:0]     wdata1,
    output logic                  ack1,
    output logic [DATA_W-1:0]     rdata1,
    output logic                  mem_en,
    output logic                  mem_we,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic [DATA_W-1:0]     mem_wdata,
    input  logic [DATA_W-1:0]     mem_rdata,
    output logic                  busy,
`ifdef MEM_PORT_ARBITER_PERF_EN
    output logic [15:0]           grant_cnt0,
    output logic [15:0]           grant_cnt1,
`endif
    output arb_state_e            dbg_state,
    output logic [WAIT_CNT_W-1:0] dbg_wait_cnt
);

    localparam logic [WAIT_CNT_W-1:0] MAX_WAIT_C = WAIT_CNT_W'(MAX_WAIT);
    localparam logic [LAT_CNT_W-1:0]  LAT_INIT   = LAT_CNT_W'(MEM_LAT - 1);

    arb_state_e            state_q;
    port_id_t              win_q;
    logic                  we_q;
    logic [LAT_CNT_W-1:0]  lat_cnt_q;
    logic [WAIT_CNT_W-1:0] wait_cnt_q;
    logic [WAIT_CNT_W-1:0] wait_cnt_d;
    logic                  ack0_q;
    logic                  ack1_q;
    logic [DATA_W-1:0]     rdata0_q;
    logic [DATA_W-1:0]     rdata1_q;
    logic                  mem_en_q;
    logic                  mem_we_q;
    logic [ADDR_W-1:0]     mem_addr_q;
    logic [DATA_W-1:0]     mem_wdata_q;

    logic                  any_req;
    port_id_t              winner;
    logic                  sel_we;
    logic [ADDR_W-1:0]     sel_addr;
    logic [DATA_W-1:0]     sel_wdata;
    logic                  enter_ack;

    mem_arb_select #(
        .MAX_WAIT (MAX_WAIT)
    ) u_select (
        .req0     (req0),
        .req1     (req1),
        .wait_cnt (wait_cnt_q),
        .any_req  (any_req),
        .winner   (winner)
    );

    assign sel_we    = winner ? we1    : we0;
    assign sel_addr  = winner ? addr1  : addr0;
    assign sel_wdata = winner ? wdata1 : wdata0;

    // Starvation count after this arbitration: clear on a port 1 grant,
    // otherwise count a loss by a requesting port 1, saturating at MAX_WAIT.
    always_comb begin
        wait_cnt_d = wait_cnt_q;
        if (winner == 1'b1) begin
            wait_cnt_d = '0;
        end else if (req1 && (wait_cnt_q != MAX_WAIT_C)) begin
            wait_cnt_d = wait_cnt_q + WAIT_CNT_W'(1);
        end
    end

    // The access completes on this edge: writes and MEM_LAT=1 reads leave ISSUE
    // directly, longer reads leave WAIT once the last latency cycle has passed.
    always_comb begin
        enter_ack = 1'b0;
        if (state_q == ISSUE) begin
            enter_ack = we_q || (MEM_LAT == 1);
        end else if (state_q == WAIT) begin
            enter_ack = (lat_cnt_q == LAT_CNT_W'(1));
        end
    end

    // Access sequencer: arbitrate, issue one memory cycle, wait out the read latency, acknowledge.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q     <= IDLE;
            win_q       <= 1'b0;
            we_q        <= 1'b0;
            lat_cnt_q   <= '0;
            wait_cnt_q  <= '0;
            ack0_q      <= 1'b0;
            ack1_q      <= 1'b0;
            rdata0_q    <= '0;
            rdata1_q    <= '0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            ack0_q <= 1'b0;
            ack1_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (any_req) begin
                        win_q       <= winner;
                        we_q        <= sel_we;
                        mem_en_q    <= 1'b1;
                        mem_we_q    <= sel_we;
                        mem_addr_q  <= sel_addr;
                        mem_wdata_q <= sel_wdata;
                        wait_cnt_q  <= wait_cnt_d;
                        state_q     <= ISSUE;
                    end
                end
                ISSUE: begin
                    mem_en_q <= 1'b0;
                    mem_we_q <= 1'b0;
                    if (enter_ack) begin
                        state_q <= ACK;
                    end else begin
                        lat_cnt_q <= LAT_INIT;
                        state_q   <= WAIT;
                    end
                end
                WAIT: begin
                    lat_cnt_q <= lat_cnt_q - LAT_CNT_W'(1);
                    if (enter_ack) begin
                        state_q <= ACK;
                    end
                end
                ACK: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
            if (enter_ack) begin
                ack0_q <= (win_q == 1'b0);
                ack1_q <= (win_q == 1'b1);
                if (!we_q) begin
                    if (win_q == 1'b1) begin
                        rdata1_q <= mem_rdata;
                    end else begin
                        rdata0_q <= mem_rdata;
                    end
                end
            end
        end
    end

`ifdef MEM_PORT_ARBITER_PERF_EN
    logic [15:0] grant_cnt0_q;
    logic [15:0] grant_cnt1_q;

    // Count completed accesses per port, saturating at all-ones.
    always_ff @(posedge clock) begin
        if (!reset) begin
            grant_cnt0_q <= '0;
            grant_cnt1_q <= '0;
        end else begin
            if (ack0_q && (grant_cnt0_q != 16'hFFFF)) begin
                grant_cnt0_q <= grant_cnt0_q + 16'd1;
            end
            if (ack1_q && (grant_cnt1_q != 16'hFFFF)) begin
                grant_cnt1_q <= grant_cnt1_q + 16'd1;
            end
        end
    end

    assign grant_cnt0 = grant_cnt0_q;
    assign grant_cnt1 = grant_cnt1_q;
`endif

    assign ack0         = ack0_q;
    assign ack1         = ack1_q;
    assign rdata0       = rdata0_q;
    assign rdata1       = rdata1_q;
    assign mem_en       = mem_en_q;
    assign mem_we       = mem_we_q;
    assign mem_addr     = mem_addr_q;
    assign mem_wdata    = mem_wdata_q;
    assign busy         = (state_q != IDLE);
    assign dbg_state    = state_q;
    assign dbg_wait_cnt = wait_cnt_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: two arbiters share one clock, A with MEM_LAT=1 and
// B with MEM_LAT=3 (both MAX_WAIT=4), each with its own memory model and
// expected-ack queue.
module tb_mem_port_arbiter;
    import mem_arb_pkg::*;

    localparam int EXP_W = 34;  // {ack cycle[15:0], port, check rdata, rdata[15:0]}

    // ---------------- clock / reset ----------------
    logic clock = 1'b0;
    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    logic a_rst_n, b_rst_n;

    // ---------------- DUT A (MEM_LAT=1) ----------------
    logic        a_req0, a_we0, a_req1, a_we1, a_ack0, a_ack1;
    logic [15:0] a_addr0, a_wdata0, a_addr1, a_wdata1, a_rdata0, a_rdata1;
    logic        a_mem_en, a_mem_we, a_busy;
    logic [15:0] a_mem_addr, a_mem_wdata, a_mem_rdata;
    arb_state_e  a_dbg_state;
    logic [3:0]  a_dbg_wait_cnt;
`ifdef MEM_PORT_ARBITER_PERF_EN
    logic [15:0] a_gc0, a_gc1, b_gc0, b_gc1;
`endif

    mem_port_arbiter #(.ADDR_W(16), .DATA_W(16), .MEM_LAT(1), .MAX_WAIT(4)) u_dut_a (
        .clock(clock), .reset(a_rst_n),
        .req0(a_req0), .we0(a_we0), .addr0(a_addr0), .wdata0(a_wdata0), .ack0(a_ack0), .rdata0(a_rdata0),
        .req1(a_req1), .we1(a_we1), .addr1(a_addr1), .wdata1(a_wdata1), .ack1(a_ack1), .rdata1(a_rdata1),
        .mem_en(a_mem_en), .mem_we(a_mem_we), .mem_addr(a_mem_addr), .mem_wdata(a_mem_wdata),
        .mem_rdata(a_mem_rdata), .busy(a_busy),
`ifdef MEM_PORT_ARBITER_PERF_EN
        .grant_cnt0(a_gc0), .grant_cnt1(a_gc1),
`endif
        .dbg_state(a_dbg_state), .dbg_wait_cnt(a_dbg_wait_cnt)
    );

    // ---------------- DUT B (MEM_LAT=3) ----------------
    logic        b_req0, b_we0, b_req1, b_we1, b_ack0, b_ack1;
    logic [15:0] b_addr0, b_wdata0, b_addr1, b_wdata1, b_rdata0, b_rdata1;
    logic        b_mem_en, b_mem_we, b_busy;
    logic [15:0] b_mem_addr, b_mem_wdata, b_mem_rdata;
    arb_state_e  b_dbg_state;
    logic [3:0]  b_dbg_wait_cnt;

    mem_port_arbiter #(.ADDR_W(16), .DATA_W(16), .MEM_LAT(3), .MAX_WAIT(4)) u_dut_b (
        .clock(clock), .reset(b_rst_n),
        .req0(b_req0), .we0(b_we0), .addr0(b_addr0), .wdata0(b_wdata0), .ack0(b_ack0), .rdata0(b_rdata0),
        .req1(b_req1), .we1(b_we1), .addr1(b_addr1), .wdata1(b_wdata1), .ack1(b_ack1), .rdata1(b_rdata1),
        .mem_en(b_mem_en), .mem_we(b_mem_we), .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata),
        .mem_rdata(b_mem_rdata), .busy(b_busy),
`ifdef MEM_PORT_ARBITER_PERF_EN
        .grant_cnt0(b_gc0), .grant_cnt1(b_gc1),
`endif
        .dbg_state(b_dbg_state), .dbg_wait_cnt(b_dbg_wait_cnt)
    );

    // ---------------- memory models ----------------
    // A: RAM with combinational read, so mem_rdata is valid in the mem_en cycle.
    logic [15:0] a_mem [0:255];
    always @(posedge clock) begin
        if (a_mem_en && a_mem_we) a_mem[a_mem_addr[7:0]] <= a_mem_wdata;
    end
    assign a_mem_rdata = a_mem[a_mem_addr[7:0]];

    // B: ROM with two pipeline stages, data valid two cycles after the mem_en cycle.
    logic [15:0] b_mem [0:255];
    logic [15:0] b_pipe0, b_pipe1;
    always @(posedge clock) begin
        b_pipe0 <= b_mem[b_mem_addr[7:0]];
        b_pipe1 <= b_pipe0;
    end
    assign b_mem_rdata = b_pipe1;

    // ---------------- scoreboard ----------------
    logic [EXP_W-1:0] a_exp_q[$];
    logic [EXP_W-1:0] b_exp_q[$];
    int n_cmp  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_exp(input bit inst, input logic [15:0] c, input logic port,
                            input logic chk_rd, input logic [15:0] rd);
        if (!inst) a_exp_q.push_back({c, port, chk_rd, rd});
        else       b_exp_q.push_back({c, port, chk_rd, rd});
    endtask

    task automatic mon_one(input bit inst);
        logic k0, k1;
        logic [15:0] r0, r1;
        logic [EXP_W-1:0] e;
        string p;
        int qsz;
        p   = inst ? "b" : "a";
        k0  = inst ? b_ack0 : a_ack0;
        k1  = inst ? b_ack1 : a_ack1;
        r0  = inst ? b_rdata0 : a_rdata0;
        r1  = inst ? b_rdata1 : a_rdata1;
        qsz = inst ? b_exp_q.size() : a_exp_q.size();
        if (k0 || k1) begin
            chk({p, "_single_ack"}, 32'(k0 && k1), 32'd0);
            if (qsz == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL %s_unexpected_ack: ack0=%0b ack1=%0b with no access outstanding (cycle %0d)",
                         p, k0, k1, cyc);
            end else begin
                if (!inst) e = a_exp_q.pop_front();
                else       e = b_exp_q.pop_front();
                chk({p, "_ack_port"}, 32'(k1), 32'(e[17]));
                chk({p, "_ack_cycle"}, 32'(cyc[15:0]), 32'(e[33:18]));
                if (e[16]) chk({p, "_rdata"}, 32'(k1 ? r1 : r0), 32'(e[15:0]));
            end
        end
    endtask

    // Monitor: compare every ack against the head of its instance's queue.
    always @(negedge clock) begin
        mon_one(1'b0);
        mon_one(1'b1);
    end

    // ---------------- driver tasks ----------------
    task automatic drive(input bit inst, input bit port, input logic req, input logic we,
                         input logic [15:0] addr, input logic [15:0] wdata);
        if (!inst && !port) begin a_req0 = req; a_we0 = we; a_addr0 = addr; a_wdata0 = wdata; end
        if (!inst &&  port) begin a_req1 = req; a_we1 = we; a_addr1 = addr; a_wdata1 = wdata; end
        if ( inst && !port) begin b_req0 = req; b_we0 = we; b_addr0 = addr; b_wdata0 = wdata; end
        if ( inst &&  port) begin b_req1 = req; b_we1 = we; b_addr1 = addr; b_wdata1 = wdata; end
    endtask

    // Single access on an idle arbiter; expected latency: write 2, read MEM_LAT+1.
    task automatic access(input bit inst, input bit port, input bit we, input logic [15:0] addr,
                          input logic [15:0] wdata, input logic [15:0] exp_rd);
        int lat, en_cnt, busy_cnt;
        bit got, k, en, bz;
        string p;
        p   = inst ? "b" : "a";
        lat = we ? 2 : ((inst ? 3 : 1) + 1);
        @(posedge clock); #1;
        push_exp(inst, 16'(cyc + lat), port, !we, exp_rd);
        drive(inst, port, 1'b1, we, addr, wdata);
        en_cnt = 0; busy_cnt = 0; got = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            en = inst ? b_mem_en : a_mem_en;
            bz = inst ? b_busy : a_busy;
            k  = inst ? (port ? b_ack1 : b_ack0) : (port ? a_ack1 : a_ack0);
            if (en) en_cnt++;
            if (bz) busy_cnt++;
            if (k) begin
                got = 1'b1;
                break;
            end
        end
        drive(inst, port, 1'b0, 1'b0, 16'h0000, 16'h0000);
        chk({p, "_ack_seen"}, 32'(got), 32'd1);
        chk({p, "_mem_en_pulses"}, 32'(en_cnt), 32'd1);
        chk({p, "_busy_cycles"}, 32'(busy_cnt), 32'(lat));
    endtask

    // Both ports of A request continuously: grants 0,0,0,0,1 twice, 3 cycles apart.
    task automatic contention();
        int exp_wc[10];
        int acks;
        exp_wc = '{1, 2, 3, 4, 0, 1, 2, 3, 4, 0};
        @(posedge clock); #1;
        for (int k = 0; k < 10; k++) begin
            push_exp(1'b0, 16'(cyc + 2 + 3 * k), logic'((k == 4) || (k == 9)), 1'b0, 16'h0000);
        end
        drive(1'b0, 1'b0, 1'b1, 1'b1, 16'h0030, 16'h1111);
        drive(1'b0, 1'b1, 1'b1, 1'b1, 16'h0031, 16'h2222);
        acks = 0;
        for (int i = 0; i < 60 && acks < 10; i++) begin
            @(negedge clock);
            if (a_ack0 || a_ack1) begin
                chk("a_wait_cnt", 32'(a_dbg_wait_cnt), 32'(exp_wc[acks]));
                acks++;
            end
        end
        drive(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000);
        chk("a_contention_acks", 32'(acks), 32'd10);
    endtask

    // Reset B while a port 0 read sits in WAIT; the access must vanish without an ack.
    task automatic reset_in_wait();
        bit reached;
        @(posedge clock); #1;
        drive(1'b1, 1'b0, 1'b1, 1'b0, 16'h0041, 16'h0000);
        reached = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            if (b_dbg_state == WAIT) begin
                reached = 1'b1;
                break;
            end
        end
        chk("b_reached_wait", 32'(reached), 32'd1);
        b_rst_n = 1'b0;
        drive(1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
        @(negedge clock);
        chk("b_rst_state", 32'(b_dbg_state), 32'(IDLE));
        chk("b_rst_busy", 32'(b_busy), 32'd0);
        chk("b_rst_ack0", 32'(b_ack0), 32'd0);
        chk("b_rst_mem_en", 32'(b_mem_en), 32'd0);
        chk("b_rst_mem_addr", 32'(b_mem_addr), 32'd0);
        chk("b_rst_rdata1", 32'(b_rdata1), 32'd0);
        chk("b_rst_wait_cnt", 32'(b_dbg_wait_cnt), 32'd0);
        repeat (2) @(negedge clock);
        @(posedge clock); #1;
        b_rst_n = 1'b1;
        repeat (3) @(negedge clock);
        chk("b_post_rst_busy", 32'(b_busy), 32'd0);
        access(1'b1, 1'b0, 1'b0, 16'h0041, 16'h0000, 16'h5A5A);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        a_rst_n = 1'b0; b_rst_n = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 16'h0, 16'h0);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
        drive(1'b1, 1'b1, 1'b0, 1'b0, 16'h0, 16'h0);
        b_mem[8'h40] = 16'hCAFE;
        b_mem[8'h41] = 16'h5A5A;
        repeat (3) @(posedge clock);
        @(negedge clock);
        chk("a_rst_state", 32'(a_dbg_state), 32'(IDLE));
        chk("a_rst_busy", 32'(a_busy), 32'd0);
        chk("a_rst_acks", 32'({a_ack0, a_ack1}), 32'd0);
        chk("a_rst_mem_en_we", 32'({a_mem_en, a_mem_we}), 32'd0);
        chk("a_rst_mem_addr", 32'(a_mem_addr), 32'd0);
        chk("a_rst_mem_wdata", 32'(a_mem_wdata), 32'd0);
        chk("a_rst_rdata0", 32'(a_rdata0), 32'd0);
        chk("a_rst_rdata1", 32'(a_rdata1), 32'd0);
        chk("a_rst_wait_cnt", 32'(a_dbg_wait_cnt), 32'd0);
        @(posedge clock); #1;
        a_rst_n = 1'b1; b_rst_n = 1'b1;

        // Port 0 alone, then port 1 alone, cross-port read-back.
        access(1'b0, 1'b0, 1'b1, 16'h0010, 16'hBEEF, 16'h0000);
        access(1'b0, 1'b0, 1'b0, 16'h0010, 16'h0000, 16'hBEEF);
        access(1'b0, 1'b1, 1'b1, 16'h0020, 16'h1234, 16'h0000);
        access(1'b0, 1'b1, 1'b0, 16'h0020, 16'h0000, 16'h1234);
        chk("a_rdata0_hold", 32'(a_rdata0), 32'hBEEF);
        access(1'b0, 1'b0, 1'b0, 16'h0020, 16'h0000, 16'h1234);
        chk("a_rdata1_hold", 32'(a_rdata1), 32'h1234);

        // Continuous contention, then read back what each port wrote.
        contention();
        access(1'b0, 1'b0, 1'b0, 16'h0031, 16'h0000, 16'h2222);
        access(1'b0, 1'b1, 1'b0, 16'h0030, 16'h0000, 16'h1111);

        // Long-latency read on B, then reset during WAIT.
        access(1'b1, 1'b1, 1'b0, 16'h0040, 16'h0000, 16'hCAFE);
        reset_in_wait();

        repeat (5) @(negedge clock);
`ifdef MEM_PORT_ARBITER_PERF_EN
        chk("a_grant_cnt0", 32'(a_gc0), 32'd12);
        chk("a_grant_cnt1", 32'(a_gc1), 32'd5);
        chk("b_grant_cnt0", 32'(b_gc0), 32'd1);
        chk("b_grant_cnt1", 32'(b_gc1), 32'd0);
`endif
        chk("a_exp_q_drained", 32'(a_exp_q.size()), 32'd0);
        chk("b_exp_q_drained", 32'(b_exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    // Global time limit so the bench always ends on its own.
    initial begin
        #200000;
        n_cmp++;
        n_fail++;
        $display("FAIL global_timeout: bench still running at cycle %0d, limit 20000", cyc);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
